// File: rtl/rx_sample_timer.sv
// USB receive sample timer: recovers bit timing from line transitions and issues
// one en_sample pulse per bit, flagging runs of samples with no transition.
module rx_sample_timer #(
    parameter int unsigned CLK_PER_BIT   = 8,
    parameter int unsigned EXTEND_PERIOD = 3,
    parameter int unsigned SAMPLE_PHASE  = 4,
    parameter int unsigned MAX_RUN       = 7
) (
    input  logic clk,
    input  logic n_rst,
    input  logic enable,
    input  logic d_plus,
    input  logic d_minus,
    input  logic clear_err,
    output logic en_sample,
    output logic edge_det,
    output logic run_err
);

    localparam int unsigned CntW  = $clog2(CLK_PER_BIT + 2);
    localparam int unsigned RunW  = $clog2(MAX_RUN + 1);
    localparam int unsigned EpMax = (EXTEND_PERIOD == 0) ? 1 : EXTEND_PERIOD;
    localparam int unsigned IdxW  = $clog2(EpMax + 1);

    typedef enum logic [1:0] {StIdle, StHunt, StTrack} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [RunW-1:0]   run_q, run_d;
    logic              run_err_q, run_err_d;
    logic              last_d_plus, last_d_minus;
    logic              set_err;
    logic              long_interval;

    assign edge_det  = enable & ((d_plus != last_d_plus) | (d_minus != last_d_minus));
    assign en_sample = (state_q == StTrack) && (cnt_q == '0);
    // A sample that brings the run count to (or keeps it at) MAX_RUN sets the flag
    assign set_err   = en_sample && !edge_det && (run_q >= RunW'(MAX_RUN - 1));
    assign run_err   = run_err_q;

    assign long_interval = (EXTEND_PERIOD != 0) && (idx_q == IdxW'(EpMax));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        run_d     = run_q;
        run_err_d = run_err_q;

        if (!enable) begin
            state_d   = StIdle;
            cnt_d     = '0;
            idx_d     = '0;
            run_d     = '0;
            run_err_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StHunt;
                end
                StHunt, StTrack: begin
                    if (edge_det) begin
                        // Realign: the interval index restarts at the first interval
                        state_d = StTrack;
                        cnt_d   = CntW'(SAMPLE_PHASE - 1);
                        idx_d   = IdxW'(1);
                        run_d   = '0;
                    end else if (en_sample) begin
                        cnt_d = long_interval ? CntW'(CLK_PER_BIT) : CntW'(CLK_PER_BIT - 1);
                        idx_d = (idx_q == IdxW'(EpMax)) ? IdxW'(1) : idx_q + IdxW'(1);
                        run_d = (run_q == RunW'(MAX_RUN)) ? run_q : run_q + RunW'(1);
                    end else if (state_q == StTrack) begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase

            if (set_err) begin
                run_err_d = 1'b1;
            end else if (clear_err) begin
                run_err_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            idx_q        <= '0;
            run_q        <= '0;
            run_err_q    <= 1'b0;
            last_d_plus  <= 1'b1;
            last_d_minus <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            run_q        <= run_d;
            run_err_q    <= run_err_d;
            last_d_plus  <= d_plus;
            last_d_minus <= d_minus;
        end
    end

endmodule

// File: doc/rx_sample_timer.md
RX_SAMPLE_TIMER -- requirements
Module: rx_sample_timer

Interface
REQ-001: Parameter CLK_PER_BIT, 8: nominal clocks per USB bit; legal range 4..63.
REQ-002: Parameter EXTEND_PERIOD, 3: every EXTEND_PERIOD-th sample interval lasts CLK_PER_BIT+1 clocks; 0 disables extension.
REQ-003: Parameter SAMPLE_PHASE, 4: clocks from a detected edge to the first sample; legal range 1..CLK_PER_BIT-1.
REQ-004: Parameter MAX_RUN, 7: consecutive samples without an edge that flag a run error; legal range 2..15.
REQ-005: clk  input  1  system clock; all state on rising edge.
REQ-006: n_rst  input  1  reset; one clock, reset asynchronous and active-low.
REQ-007: enable  input  1  timer run; low forces IDLE.
REQ-008: d_plus  input  1  synchronised USB D+ line.
REQ-009: d_minus  input  1  synchronised USB D- line.
REQ-010: clear_err  input  1  synchronous clear of run_err.
REQ-011: en_sample  output  1  single-cycle pulse; downstream samples line in this cycle.
REQ-012: edge_det  output  1  combinational edge indication, gated by enable.
REQ-013: run_err  output  1  sticky flag: MAX_RUN samples with no line transition.

Function
REQ-014: Registers last_d_plus/last_d_minus capture d_plus/d_minus every cycle, regardless of state.
REQ-015: edge_det = enable AND ((d_plus != last_d_plus) OR (d_minus != last_d_minus)).
REQ-016: States IDLE, HUNT, TRACK; IDLE->HUNT when enable=1; HUNT->TRACK on edge_det; any state->IDLE the cycle after enable=0.
REQ-017: IDLE and HUNT produce no en_sample.
REQ-018: Edge detected in cycle E (HUNT or TRACK): first en_sample in cycle E+SAMPLE_PHASE unless another edge intervenes.
REQ-019: After the first sample, subsequent en_sample pulses spaced CLK_PER_BIT clocks, except every EXTEND_PERIOD-th interval (3rd, 6th, ... counted from the edge) is CLK_PER_BIT+1 clocks.
REQ-020: Every edge in TRACK realigns: phase counter and interval index restart per REQ-018/019.
REQ-021: Edge in the same cycle a sample is due: en_sample still pulses that cycle; realignment per REQ-018 from that cycle.
REQ-022: Run counter increments on each en_sample, clears on each edge, saturates at MAX_RUN.
REQ-023: run_err sets the cycle after the run counter reaches MAX_RUN; remains set until clear_err=1 or IDLE entry; clears the cycle after clear_err.
REQ-024: clear_err and a same-cycle set condition: set wins.
REQ-025: Counter widths sized from parameters (clog2(CLK_PER_BIT+2), clog2(MAX_RUN+1)); no wrap beyond parameter ranges.

Reset
REQ-026: On n_rst=0: state IDLE, en_sample=0, run_err=0, all counters 0, last_d_plus=1, last_d_minus=0 (USB idle J).
REQ-027: Reset deassertion mid-packet: block restarts in IDLE/HUNT; no sample until a new edge.

Verification
REQ-028: Reset with d_plus=1,d_minus=0 -> en_sample=0, run_err=0, edge_det=0; no pulses while enable=0 and lines toggle.
REQ-029: Defaults, enable=1, single edge at cycle 10, lines static -> en_sample at 14,22,30,39,47,55,64; run_err=1 from 65.
REQ-030: Edges at 10 and 27 -> en_sample at 14,22,31,39,47,56; no pulse at 30.
REQ-031: Edge at 10, second edge at 22 (sample due) -> pulses at 14,22,26,34,42,51.
REQ-032: run_err set at 65, clear_err=1 at 70 -> run_err=0 at 71; clear_err held while set condition recurs -> run_err stays 1.
REQ-033: enable dropped at cycle 40 during TRACK -> IDLE at 41, no en_sample from 41, run_err=0; edge after re-enable realigns per REQ-018.
